// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: data-memory wait states and
// register index helpers.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {MW_IDLE, MW_WAIT, MW_ERR} memwait_e;

  typedef logic [4:0] reg_idx;

  localparam reg_idx REG_ZERO = 5'd0;

  // One source operand of the D instruction depends on the E destination.
  function automatic logic src_hit(input logic used, input reg_idx rs, input reg_idx rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait sequencer: tracks req/ack, counts wait cycles and latches a
// timeout error that only reset clears.
module mem_wait_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic dmem_ack,
  output logic memstall,
  output logic mem_err
);

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  memwait_e    state, state_nxt;
  logic [15:0] wcnt, wcnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MW_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    memstall  = 1'b0;
    case (state)
      MW_IDLE: begin
        if (mem_req && !dmem_ack) begin
          memstall  = 1'b1;
          state_nxt = MW_WAIT;
          wcnt_nxt  = 16'd1;
        end
      end
      MW_WAIT: begin
        if (dmem_ack) begin
          state_nxt = MW_IDLE;
          wcnt_nxt  = '0;
        end else begin
          memstall = 1'b1;
          if (wcnt == TIMEOUT) state_nxt = MW_ERR;
          else                 wcnt_nxt  = wcnt + 16'd1;
        end
      end
      MW_ERR:  memstall = 1'b1;
      default: state_nxt = MW_IDLE;
    endcase
  end

  assign mem_err = (state == MW_ERR);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, branch redirect
// and load-use priority. Optional perf counters under PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic       rs1_used_D,
  input  logic       rs2_used_D,
  input  logic [4:0] rd_E,
  input  logic       ld_E,
  input  logic       br_taken_E,
  input  logic       mem_req_M,
  input  logic       dmem_ack,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       stall_M,
  output logic       flush_D,
  output logic       flush_E,
  output logic       en_W,
  output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic memstall;
  logic loaduse;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req_M),
    .dmem_ack (dmem_ack),
    .memstall (memstall),
    .mem_err  (mem_err)
  );

  assign loaduse = ld_E && (rd_E != REG_ZERO) &&
                   (src_hit(rs1_used_D, rs1_D, rd_E) || src_hit(rs2_used_D, rs2_D, rd_E));

  // Priority: reset, memory stall (freezes E, so branch/load-use retry later),
  // branch (D holds a wrong-path instr), then load-use bubble.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    en_W    = 1'b1;
    if (!rst) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      en_W    = 1'b0;
    end else if (memstall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      en_W    = 1'b0;
    end else if (br_taken_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (loaduse) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_F && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_E && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a random run
// against a behavioural model, on two instances (MEM_TIMEOUT 255 and 4).
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1_D, rs2_D, rd_E;
  logic       rs1_used_D, rs2_used_D, ld_E, br_taken_E, mem_req_M, dmem_ack;

  logic [1:0] s_f, s_d, s_e, s_m, f_d, f_e, en_w, m_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] sc0, fc0;
  logic [3:0]  sc1, fc1;
`endif

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(255)
`ifdef PIPE_PERF_CNT_EN
    , .CNT_W(32)
`endif
  ) dut0 (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E), .ld_E(ld_E),
    .br_taken_E(br_taken_E), .mem_req_M(mem_req_M), .dmem_ack(dmem_ack),
    .stall_F(s_f[0]), .stall_D(s_d[0]), .stall_E(s_e[0]), .stall_M(s_m[0]),
    .flush_D(f_d[0]), .flush_E(f_e[0]), .en_W(en_w[0]), .mem_err(m_err[0])
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
  );

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(4)
`ifdef PIPE_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut1 (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E), .ld_E(ld_E),
    .br_taken_E(br_taken_E), .mem_req_M(mem_req_M), .dmem_ack(dmem_ack),
    .stall_F(s_f[1]), .stall_D(s_d[1]), .stall_E(s_e[1]), .stall_M(s_m[1]),
    .flush_D(f_d[1]), .flush_E(f_e[1]), .en_W(en_w[1]), .mem_err(m_err[1])
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  // Output vector {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,en_W,mem_err}
  localparam logic [7:0] O_RST  = 8'b0000_1100;
  localparam logic [7:0] O_IDLE = 8'b0000_0010;
  localparam logic [7:0] O_MEM  = 8'b1111_0000;
  localparam logic [7:0] O_ERR  = 8'b1111_0001;
  localparam logic [7:0] O_LU   = 8'b1100_0110;
  localparam logic [7:0] O_BR   = 8'b0000_1110;

  function automatic logic [7:0] obs(input int i);
    return {s_f[i], s_d[i], s_e[i], s_m[i], f_d[i], f_e[i], en_w[i], m_err[i]};
  endfunction

  // Apply one cycle of inputs just after the falling edge; outputs are then
  // stable for sampling well before the next rising edge.
  task automatic set_in(input logic r, input logic [4:0] a, input logic ua,
                        input logic [4:0] b, input logic ub, input logic [4:0] d,
                        input logic l, input logic br, input logic rq, input logic ak);
    @(negedge clk);
    rst = r; rs1_D = a; rs1_used_D = ua; rs2_D = b; rs2_used_D = ub;
    rd_E = d; ld_E = l; br_taken_E = br; mem_req_M = rq; dmem_ack = ak;
    #1;
  endtask

  task automatic idle_cycle(input logic r);
    set_in(r, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    for (int i = 0; i < 7; i++) set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    checks++;
    if (obs(0) !== O_MEM) begin
      failures++; $display("FAIL reset_prewait dut0 got=%b exp=%b", obs(0), O_MEM);
    end
    checks++;
    if (obs(1) !== O_ERR) begin
      failures++; $display("FAIL reset_prewait dut1 got=%b exp=%b", obs(1), O_ERR);
    end
    set_in(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== O_RST) begin
        failures++; $display("FAIL reset_assert dut%0d got=%b exp=%b", i, obs(i), O_RST);
      end
    end
    idle_cycle(1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== O_IDLE) begin
        failures++; $display("FAIL reset_release dut%0d got=%b exp=%b", i, obs(i), O_IDLE);
      end
    end
  endtask

  task automatic test_load_use;
    logic [7:0] exp_v [5];
    exp_v = '{O_LU, O_IDLE, O_IDLE, O_LU, O_IDLE};
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: set_in(1, 5'd3, 1, 5'd5, 1, 5'd5, 1, 0, 0, 0);
        1: set_in(1, 5'd3, 1, 5'd5, 1, 5'd5, 0, 0, 0, 0);
        2: set_in(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0);
        3: set_in(1, 5'd9, 1, 5'd2, 0, 5'd9, 1, 0, 0, 0);
        default: set_in(1, 5'd9, 0, 5'd9, 0, 5'd9, 1, 0, 0, 0);
      endcase
      checks++;
      if (obs(0) !== exp_v[k]) begin
        failures++; $display("FAIL load_use step%0d got=%b exp=%b", k, obs(0), exp_v[k]);
      end
    end
  endtask

  task automatic test_dmem_wait;
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (obs(0) !== O_MEM) begin
        failures++; $display("FAIL dmem_wait cyc%0d got=%b exp=%b", k, obs(0), O_MEM);
      end
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (obs(0) !== O_IDLE) begin
      failures++; $display("FAIL dmem_ack_release got=%b exp=%b", obs(0), O_IDLE);
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (obs(0) !== O_IDLE) begin
      failures++; $display("FAIL dmem_zero_wait got=%b exp=%b", obs(0), O_IDLE);
    end
    idle_cycle(1'b1);
  endtask

  task automatic test_branch_loaduse;
    set_in(1, 5'd7, 1, 5'd1, 0, 5'd7, 1, 1, 0, 0);
    checks++;
    if (obs(0) !== O_BR) begin
      failures++; $display("FAIL br_beats_lu got=%b exp=%b", obs(0), O_BR);
    end
    for (int k = 0; k < 2; k++) begin
      set_in(1, 5'd7, 1, 5'd1, 0, 5'd7, 1, 1, 1, 0);
      checks++;
      if (obs(0) !== O_MEM) begin
        failures++; $display("FAIL br_in_memstall cyc%0d got=%b exp=%b", k, obs(0), O_MEM);
      end
    end
    set_in(1, 5'd7, 1, 5'd1, 0, 5'd7, 1, 1, 1, 1);
    checks++;
    if (obs(0) !== O_BR) begin
      failures++; $display("FAIL br_after_ack got=%b exp=%b", obs(0), O_BR);
    end
    idle_cycle(1'b1);
  endtask

  task automatic test_timeout;
    logic [7:0] e;
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    for (int k = 0; k < 8; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      e = (k >= 5) ? O_ERR : O_MEM;
      checks++;
      if (obs(1) !== e) begin
        failures++; $display("FAIL timeout cyc%0d got=%b exp=%b", k, obs(1), e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      checks++;
      if (obs(1) !== O_ERR) begin
        failures++; $display("FAIL err_sticky cyc%0d got=%b exp=%b", k, obs(1), O_ERR);
      end
    end
    checks++;
    if (obs(0) !== O_BR) begin
      failures++; $display("FAIL no_timeout_dut0 got=%b exp=%b", obs(0), O_BR);
    end
    idle_cycle(1'b0);
    checks++;
    if (obs(1) !== O_RST) begin
      failures++; $display("FAIL err_reset got=%b exp=%b", obs(1), O_RST);
    end
    idle_cycle(1'b1);
    checks++;
    if (obs(1) !== O_IDLE) begin
      failures++; $display("FAIL err_cleared got=%b exp=%b", obs(1), O_IDLE);
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt;
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    for (int k = 0; k < 10; k++) set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 2; k++) set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle_cycle(1'b1);
    checks++;
    if (sc0 !== 32'd10) begin
      failures++; $display("FAIL stall_cnt got=%0d exp=10", sc0);
    end
    checks++;
    if (fc0 !== 32'd2) begin
      failures++; $display("FAIL flush_cnt got=%0d exp=2", fc0);
    end
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    for (int k = 0; k < 20; k++) set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_cycle(1'b1);
    checks++;
    if (sc1 !== 4'd15) begin
      failures++; $display("FAIL stall_cnt_sat got=%0d exp=15", sc1);
    end
    checks++;
    if (fc1 !== 4'd0) begin
      failures++; $display("FAIL flush_cnt_sat got=%0d exp=0", fc1);
    end
  endtask
`endif

  // Behavioural model: a memory access stalls until acked; an access that has
  // stalled MEM_TIMEOUT cycles after its first cycle becomes a permanent error.
  function automatic logic [7:0] model_out(input logic err, input logic waiting);
    logic ms, lu;
    if (!rst) return O_RST;
    ms = err || (waiting ? !dmem_ack : (mem_req_M && !dmem_ack));
    lu = ld_E && rd_E != 0 &&
         ((rs1_used_D && rs1_D == rd_E) || (rs2_used_D && rs2_D == rd_E));
    if (ms)         return {O_MEM[7:1], err};
    if (br_taken_E) return O_BR;
    if (lu)         return O_LU;
    return O_IDLE;
  endfunction

  task automatic test_random;
    logic        m_errf [2];
    logic        m_wait [2];
    int unsigned m_n    [2];
    int unsigned m_to   [2];
    logic [31:0] m_sc   [2];
    logic [31:0] m_fc   [2];
    logic [31:0] m_max  [2];
    logic [7:0]  e;
    m_to  = '{255, 4};
    m_max = '{32'hFFFF_FFFF, 32'd15};
    idle_cycle(1'b0);
    for (int i = 0; i < 2; i++) begin
      m_errf[i] = 0; m_wait[i] = 0; m_n[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      set_in(($urandom_range(99) >= 3) ? 1'b1 : 1'b0,
             5'($urandom_range(3)), 1'($urandom_range(1)),
             5'($urandom_range(3)), 1'($urandom_range(1)),
             5'($urandom_range(3)), 1'($urandom_range(99) < 40),
             1'($urandom_range(99) < 20), 1'($urandom_range(99) < 40),
             1'($urandom_range(99) < 35));
      for (int i = 0; i < 2; i++) begin
        e = model_out(m_errf[i], m_wait[i]);
        checks++;
        if (obs(i) !== e) begin
          failures++; $display("FAIL random c%0d dut%0d got=%b exp=%b", c, i, obs(i), e);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if ((i == 0 ? sc0 : {28'd0, sc1}) !== m_sc[i] ||
            (i == 0 ? fc0 : {28'd0, fc1}) !== m_fc[i]) begin
          failures++;
          $display("FAIL random_cnt c%0d dut%0d got=%0d/%0d exp=%0d/%0d", c, i,
                   (i == 0 ? sc0 : {28'd0, sc1}), (i == 0 ? fc0 : {28'd0, fc1}),
                   m_sc[i], m_fc[i]);
        end
`endif
        if (!rst) begin
          m_errf[i] = 0; m_wait[i] = 0; m_n[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end else begin
          if (e[7] && m_sc[i] != m_max[i]) m_sc[i]++;
          if (e[2] && m_fc[i] != m_max[i]) m_fc[i]++;
          if (!m_errf[i]) begin
            if (m_wait[i]) begin
              if (dmem_ack)              m_wait[i] = 0;
              else if (m_n[i] == m_to[i]) begin m_errf[i] = 1; m_wait[i] = 0; end
              else                        m_n[i]++;
            end else if (mem_req_M && !dmem_ack) begin
              m_wait[i] = 1; m_n[i] = 1;
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; rs1_D = '0; rs2_D = '0; rd_E = '0;
    rs1_used_D = 0; rs2_used_D = 0; ld_E = 0; br_taken_E = 0; mem_req_M = 0; dmem_ack = 0;
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_branch_loaduse();
    test_timeout();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
